// File: rtl/controlador_estados_param_pkg.sv
// Shared state encodings, permanence width and IDLE button decoding for the pet controller.
package controlador_pkg;

  localparam logic [3:0] EST_IDLE       = 4'b0000;
  localparam logic [3:0] EST_DORMINDO   = 4'b0001;
  localparam logic [3:0] EST_COMENDO    = 4'b0010;
  localparam logic [3:0] EST_DANDO_AULA = 4'b0100;
  localparam logic [3:0] EST_MORTO      = 4'b1000;

  localparam int unsigned PERM_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE       = EST_IDLE,
    ST_DORMINDO   = EST_DORMINDO,
    ST_COMENDO    = EST_COMENDO,
    ST_DANDO_AULA = EST_DANDO_AULA,
    ST_MORTO      = EST_MORTO
  } estado_e;

  // Activity chosen from IDLE for a given pair of latched presses.
  function automatic estado_e prox_de_idle(input logic p1, input logic p2);
    estado_e prox;
    case ({p1, p2})
      2'b10:   prox = ST_COMENDO;
      2'b01:   prox = ST_DORMINDO;
      2'b11:   prox = ST_DANDO_AULA;
      default: prox = ST_IDLE;
    endcase
    return prox;
  endfunction

endpackage

// File: rtl/controlador_estados_param_if.sv
// Button/stat inputs and state/pulse outputs of the pet controller.
interface controlador_estados_param_if #(
  parameter int unsigned W = 8
) ();

  logic                              b1;
  logic                              b2;
  logic [W-1:0]                      fome;
  logic [W-1:0]                      felicidade;
  logic [W-1:0]                      sono;
  logic [3:0]                        estado;
  logic                              tick;
  logic                              mudou;
  logic [controlador_pkg::PERM_W-1:0] permanencia;

  modport master (
    output b1, b2, fome, felicidade, sono,
    input  estado, tick, mudou, permanencia
  );

  modport slave (
    input  b1, b2, fome, felicidade, sono,
    output estado, tick, mudou, permanencia
  );

endinterface

// File: rtl/controlador_estados_param_gerador_tick.sv
// Free-running 0..TICK_PERIOD-1 counter; decisao_c marks the last cycle of each window.
module gerador_tick #(
  parameter int unsigned TICK_PERIOD = 65536
) (
  input  logic clk,
  input  logic rst_n,
  output logic decisao_c
);

  localparam int unsigned CNT_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    decisao_c = (cnt_q == CNT_MAX);
    cnt_d     = decisao_c ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/controlador_estados_param.sv
// Pet activity controller: latches buttons per window and decides estado once per tick.
// Optional automatic sleep/wake on sono is enabled by defining CONTROLADOR_AUTO_SONO_EN.
module controlador_estados_param
  import controlador_pkg::*;
#(
  parameter int unsigned W           = 8,
  parameter int unsigned TICK_PERIOD = 65536,
  parameter int unsigned MIN_DWELL   = 2,
  parameter int unsigned MAX_AULA    = 8,
  parameter int unsigned LIMIAR_SONO = 16
) (
  input logic                        clk,
  input logic                        rst_n,
  controlador_estados_param_if.slave bus
);

`ifdef CONTROLADOR_AUTO_SONO_EN
  localparam bit AUTO_SONO = 1'b1;
`else
  localparam bit AUTO_SONO = 1'b0;
`endif

  localparam logic [W-1:0]      LIMIAR    = W'(LIMIAR_SONO);
  localparam logic [PERM_W:0]   DWELL_MIN = (PERM_W + 1)'(MIN_DWELL);
  localparam logic [PERM_W:0]   AULA_MAX  = (PERM_W + 1)'(MAX_AULA);

  logic decisao_c;

  gerador_tick #(
    .TICK_PERIOD (TICK_PERIOD)
  ) u_gerador_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .decisao_c (decisao_c)
  );

  estado_e           estado_q, estado_d;
  logic              tick_q, tick_d;
  logic              mudou_q, mudou_d;
  logic [PERM_W-1:0] perm_q, perm_d;
  logic              b1_l_q, b1_l_d;
  logic              b2_l_q, b2_l_d;

  logic              p1, p2;
  logic [PERM_W:0]   perm_inc;
  logic              stat_zero;
  logic              sono_baixo;
  logic              sono_cheio;

  // Next-state decision; everything except the latches holds between ticks.
  always_comb begin
    estado_d   = estado_q;
    tick_d     = 1'b0;
    mudou_d    = 1'b0;
    perm_d     = perm_q;
    b1_l_d     = b1_l_q | bus.b1;
    b2_l_d     = b2_l_q | bus.b2;
    p1         = b1_l_q | bus.b1;
    p2         = b2_l_q | bus.b2;
    perm_inc   = {1'b0, perm_q} + (PERM_W + 1)'(1);
    stat_zero  = (bus.fome == '0) || (bus.felicidade == '0) || (bus.sono == '0);
    sono_baixo = AUTO_SONO && (bus.sono < LIMIAR);
    sono_cheio = AUTO_SONO && (bus.sono == '1);

    if (decisao_c) begin
      b1_l_d = 1'b0;
      b2_l_d = 1'b0;
      tick_d = 1'b1;

      if (estado_q == ST_MORTO) begin
        estado_d = ST_MORTO;
      end else if (stat_zero) begin
        estado_d = ST_MORTO;
      end else begin
        case (estado_q)
          ST_IDLE: begin
            if (sono_baixo) estado_d = ST_DORMINDO;
            else            estado_d = prox_de_idle(p1, p2);
          end
          ST_DORMINDO, ST_COMENDO, ST_DANDO_AULA: begin
            // Wake-up and class timeout take precedence over the dwell guard.
            if (estado_q == ST_DORMINDO && sono_cheio) begin
              estado_d = ST_IDLE;
            end else if (estado_q == ST_DANDO_AULA && perm_inc >= AULA_MAX) begin
              estado_d = ST_IDLE;
            end else if (perm_inc < DWELL_MIN) begin
              estado_d = estado_q;
            end else if (p1 || p2) begin
              estado_d = ST_IDLE;
            end else begin
              estado_d = estado_q;
            end
          end
          default: estado_d = ST_IDLE;
        endcase
      end

      mudou_d = (estado_d != estado_q);
      if (mudou_d)              perm_d = '0;
      else if (perm_q == '1)    perm_d = perm_q;
      else                      perm_d = perm_q + PERM_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= ST_IDLE;
      tick_q   <= 1'b0;
      mudou_q  <= 1'b0;
      perm_q   <= '0;
      b1_l_q   <= 1'b0;
      b2_l_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      tick_q   <= tick_d;
      mudou_q  <= mudou_d;
      perm_q   <= perm_d;
      b1_l_q   <= b1_l_d;
      b2_l_q   <= b2_l_d;
    end
  end

  assign bus.estado      = estado_q;
  assign bus.tick        = tick_q;
  assign bus.mudou       = mudou_q;
  assign bus.permanencia = perm_q;

endmodule
